// File: rtl/boot_loader_ctrl_pkg.sv
// Shared definitions for the boot loader: command opcodes, FSM states, defaults.
package boot_loader_ctrl_pkg;

    localparam int unsigned MaxWordsDefault = 256;

    // Command opcodes carried in bits [7:0] of a command word
    localparam logic [7:0] OpLoadImem = 8'h01;
    localparam logic [7:0] OpLoadDmem = 8'h02;
    localparam logic [7:0] OpRun      = 8'h03;
    localparam logic [7:0] OpHalt     = 8'h04;

    // Byte counter value at which the fourth byte of a word arrives
    localparam logic [1:0] ByteCntLast = 2'd3;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoadI = 3'd1,
        StLoadD = 3'd2,
        StRun   = 3'd3,
        StError = 3'd4
    } loader_state_e;

    function automatic logic is_load(input logic [7:0] op);
        return (op == OpLoadImem) || (op == OpLoadDmem);
    endfunction

endpackage

// File: rtl/boot_loader_ctrl_packer.sv
// Assembles accepted bytes (little-endian) into 32-bit words; pulses word_valid_o
// for one cycle after the edge that accepts the fourth byte.
module boot_loader_ctrl_packer
    import boot_loader_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;

    // Next-state: shift in bytes, emit the word when the fourth byte lands
    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (byte_valid_i) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == ByteCntLast) begin
                word_d       = {byte_i, shift_q};
                word_valid_d = 1'b1;
            end else begin
                // Newest byte enters at the top so the first byte ends up in [7:0]
                shift_d = {byte_i, shift_q[23:8]};
            end
        end
    end

    // State register; reset discards any partial word
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= 2'd0;
            shift_q      <= 24'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader controller: decodes command words from a byte stream, writes
// payload words into instruction or data BRAM, then releases the core.
module boot_loader_ctrl
    import boot_loader_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WORDS  = MaxWordsDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic                  d_bram_init_done,
    output logic                  pc_stall,
    output logic                  i_r_enb,
    output logic                  rd_enbl,
    output logic                  busy,
    output logic                  err
);

    localparam logic [15:0] MaxN = 16'(MAX_WORDS);

    loader_state_e state_q, state_d;
    logic [15:0]   idx_q, idx_d;
    logic [15:0]   rem_q, rem_d;

    logic                  rx_ready_q, rx_ready_d;
    logic                  run_q, run_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] i_w_addr_q, i_w_addr_d;
    logic [DATA_WIDTH-1:0] i_w_dat_q, i_w_dat_d;
    logic                  i_w_enb_q, i_w_enb_d;
    logic [ADDR_WIDTH-1:0] d_w_addr_q, d_w_addr_d;
    logic [DATA_WIDTH-1:0] d_w_dat_q, d_w_dat_d;
    logic                  d_w_enb_q, d_w_enb_d;

    logic [31:0] word;
    logic        word_valid;
    logic [7:0]  opcode;
    logic [15:0] word_n;

    assign opcode = word[7:0];
    assign word_n = word[31:16];

    boot_loader_ctrl_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .byte_i       (rx_data),
        .byte_valid_i (rx_valid & rx_ready_q),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // Next-state and registered-output decode for the command FSM
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        i_w_addr_d = i_w_addr_q;
        i_w_dat_d  = i_w_dat_q;
        i_w_enb_d  = 1'b0;
        d_w_addr_d = d_w_addr_q;
        d_w_dat_d  = d_w_dat_q;
        d_w_enb_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (word_valid) begin
                    if (is_load(opcode)) begin
                        if (word_n > MaxN) begin
                            state_d = StError;
                        end else if (word_n != 16'd0) begin
                            state_d = (opcode == OpLoadImem) ? StLoadI : StLoadD;
                            idx_d   = 16'd0;
                            rem_d   = word_n;
                        end
                    end else if (opcode == OpRun) begin
                        state_d = StRun;
                    end else if (opcode != OpHalt) begin
                        state_d = StError;
                    end
                end
            end
            StLoadI, StLoadD: begin
                if (word_valid) begin
                    if (state_q == StLoadI) begin
                        i_w_enb_d  = 1'b1;
                        i_w_addr_d = ADDR_WIDTH'({idx_q, 2'b00});
                        i_w_dat_d  = DATA_WIDTH'(word);
                    end else begin
                        d_w_enb_d  = 1'b1;
                        d_w_addr_d = ADDR_WIDTH'({idx_q, 2'b00});
                        d_w_dat_d  = DATA_WIDTH'(word);
                    end
                    idx_d = idx_q + 16'd1;
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            StRun: begin
                if (word_valid && (opcode == OpHalt)) begin
                    state_d = StIdle;
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StError;
            end
        endcase

        // Status outputs follow the state being entered so they change with it
        rx_ready_d = (state_d != StError);
        run_d      = (state_d == StRun);
        busy_d     = (state_d == StLoadI) || (state_d == StLoadD);
        err_d      = (state_d == StError);
    end

    // State and output registers; BRAM contents are never touched by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= 16'd0;
            rem_q      <= 16'd0;
            rx_ready_q <= 1'b0;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            i_w_addr_q <= '0;
            i_w_dat_q  <= '0;
            i_w_enb_q  <= 1'b0;
            d_w_addr_q <= '0;
            d_w_dat_q  <= '0;
            d_w_enb_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            rx_ready_q <= rx_ready_d;
            run_q      <= run_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            i_w_addr_q <= i_w_addr_d;
            i_w_dat_q  <= i_w_dat_d;
            i_w_enb_q  <= i_w_enb_d;
            d_w_addr_q <= d_w_addr_d;
            d_w_dat_q  <= d_w_dat_d;
            d_w_enb_q  <= d_w_enb_d;
        end
    end

    assign rx_ready         = rx_ready_q;
    assign i_w_addr         = i_w_addr_q;
    assign i_w_dat          = i_w_dat_q;
    assign i_w_enb          = i_w_enb_q;
    assign d_w_addr         = d_w_addr_q;
    assign d_w_dat          = d_w_dat_q;
    assign d_w_enb          = d_w_enb_q;
    assign d_bram_init_done = run_q;
    assign pc_stall         = ~run_q;
    assign i_r_enb          = run_q;
    assign rd_enbl          = run_q;
    assign busy             = busy_q;
    assign err              = err_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl: table of command words, hand-written corner
// sequences, and randomized command streams checked against a byte-level model.
module tb_boot_loader_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;

    localparam int MIdle  = 0;
    localparam int MLoadI = 1;
    localparam int MLoadD = 2;
    localparam int MRun   = 3;
    localparam int MErr   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [AW-1:0] i_w_addr;
    logic [DW-1:0] i_w_dat;
    logic          i_w_enb;
    logic [AW-1:0] d_w_addr;
    logic [DW-1:0] d_w_dat;
    logic          d_w_enb;
    logic          d_bram_init_done;
    logic          pc_stall;
    logic          i_r_enb;
    logic          rd_enbl;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    boot_loader_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_WORDS  (256)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .i_w_addr         (i_w_addr),
        .i_w_dat          (i_w_dat),
        .i_w_enb          (i_w_enb),
        .d_w_addr         (d_w_addr),
        .d_w_dat          (d_w_dat),
        .d_w_enb          (d_w_enb),
        .d_bram_init_done (d_bram_init_done),
        .pc_stall         (pc_stall),
        .i_r_enb          (i_r_enb),
        .rd_enbl          (rd_enbl),
        .busy             (busy),
        .err              (err)
    );

    int n_vec;
    int n_fail;
    int d_wr_seen;

    // Reference model: accepted bytes queue up until four form a word, which
    // the loader acts on one edge later.
    int          m_mode;
    bit          m_rdy;
    logic [7:0]  m_bytes[$];
    bit          m_pend;
    logic [31:0] m_word;
    int          m_k;
    int          m_rem;
    bit          e_i_en;
    bit          e_d_en;
    logic [9:0]  e_addr;
    logic [31:0] e_dat;

    typedef struct {
        logic [31:0] word;
        int          wr;     // 0 none, 1 instruction BRAM, 2 data BRAM
        logic [9:0]  addr;
        bit          busy;
        bit          run;
        bit          err;
        bit          gap;
    } vec_t;

    vec_t tbl[16];

    task automatic model_consume(input logic [31:0] w);
        logic [7:0] op;
        int         n;
        op = w[7:0];
        n  = int'(w[31:16]);
        case (m_mode)
            MIdle: begin
                if (op == 8'h01 || op == 8'h02) begin
                    if (n > 256) m_mode = MErr;
                    else if (n > 0) begin
                        m_mode = (op == 8'h01) ? MLoadI : MLoadD;
                        m_k    = 0;
                        m_rem  = n;
                    end
                end else if (op == 8'h03) m_mode = MRun;
                else if (op != 8'h04) m_mode = MErr;
            end
            MLoadI, MLoadD: begin
                e_addr = 10'((4 * m_k) % 1024);
                e_dat  = w;
                if (m_mode == MLoadI) e_i_en = 1'b1;
                else e_d_en = 1'b1;
                m_k++;
                m_rem--;
                if (m_rem == 0) m_mode = MIdle;
            end
            MRun: if (op == 8'h04) m_mode = MIdle;
            default: ;
        endcase
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [7:0] d);
        bit acc;
        e_i_en = 1'b0;
        e_d_en = 1'b0;
        if (r) begin
            m_mode = MIdle;
            m_bytes.delete();
            m_pend = 1'b0;
            m_rdy  = 1'b0;
        end else begin
            acc = v && m_rdy;
            if (m_pend) begin
                m_pend = 1'b0;
                model_consume(m_word);
            end
            if (acc) begin
                m_bytes.push_back(d);
                if (m_bytes.size() == 4) begin
                    m_word = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    m_pend = 1'b1;
                    m_bytes.delete();
                end
            end
            m_rdy = (m_mode != MErr);
        end
    endtask

    task automatic check_outputs();
        logic [8:0] act;
        logic [8:0] exp;
        bit         run;
        run = (m_mode == MRun);
        act = {rx_ready, busy, err, pc_stall, i_r_enb, rd_enbl, d_bram_init_done,
               i_w_enb, d_w_enb};
        exp = {m_rdy, (m_mode == MLoadI) || (m_mode == MLoadD), m_mode == MErr, !run,
               run, run, run, e_i_en, e_d_en};
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL flags t=%0t: got %b, expected %b", $time, act, exp);
        end
        if (e_i_en) begin
            n_vec++;
            if ({i_w_addr, i_w_dat} !== {e_addr, e_dat}) begin
                n_fail++;
                $display("FAIL i_write t=%0t: got %h/%h, expected %h/%h", $time,
                         i_w_addr, i_w_dat, e_addr, e_dat);
            end
        end
        if (e_d_en) begin
            n_vec++;
            if ({d_w_addr, d_w_dat} !== {e_addr, e_dat}) begin
                n_fail++;
                $display("FAIL d_write t=%0t: got %h/%h, expected %h/%h", $time,
                         d_w_addr, d_w_dat, e_addr, e_dat);
            end
        end
        if (d_w_enb) d_wr_seen++;
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d);
        rst      = r;
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        model_edge(r, v, d);
        #1;
        check_outputs();
    endtask

    // gap < 0: random idle cycles before each byte; otherwise idles between bytes
    task automatic send_word(input logic [31:0] w, input int gap);
        int ng;
        for (int b = 0; b < 4; b++) begin
            ng = (gap < 0) ? int'($urandom_range(0, 2)) : ((b > 0) ? gap : 0);
            for (int g = 0; g < ng; g++) step(1'b0, 1'b0, 8'($urandom));
            step(1'b0, 1'b1, w[8*b +: 8]);
        end
    endtask

    task automatic check_reset_vals(input string name);
        logic [8:0] act;
        act = {rx_ready, pc_stall, busy, err, i_w_enb, d_w_enb, d_bram_init_done,
               i_r_enb, rd_enbl};
        n_vec++;
        if (act !== 9'b0_1000_0000) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, 9'b0_1000_0000);
        end
    endtask

    task automatic check_row(input int idx, input vec_t r);
        logic [46:0] act;
        logic [46:0] exp;
        logic [1:0]  ew;
        ew  = (r.wr == 1) ? 2'b10 : ((r.wr == 2) ? 2'b01 : 2'b00);
        act = {i_w_enb, d_w_enb,
               i_w_enb ? i_w_addr : (d_w_enb ? d_w_addr : 10'h0),
               i_w_enb ? i_w_dat : (d_w_enb ? d_w_dat : 32'h0),
               busy, !pc_stall, err};
        exp = {ew, (r.wr != 0) ? r.addr : 10'h0, (r.wr != 0) ? r.word : 32'h0,
               r.busy, r.run, r.err};
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL table_row%0d: got %h, expected %h", idx, act, exp);
        end
    endtask

    initial begin
        logic [31:0] w;
        int          r;
        int          n;
        n_vec     = 0;
        n_fail    = 0;
        d_wr_seen = 0;
        m_mode    = MIdle;
        m_rdy     = 1'b0;
        m_pend    = 1'b0;
        m_k       = 0;
        m_rem     = 0;
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;

        //            word          wr addr   busy run err gap
        tbl[0]  = '{32'h00030001, 0, 10'h000, 1, 0, 0, 0};
        tbl[1]  = '{32'h00500293, 1, 10'h000, 1, 0, 0, 1};
        tbl[2]  = '{32'h00300313, 1, 10'h004, 1, 0, 0, 0};
        tbl[3]  = '{32'h00628463, 1, 10'h008, 0, 0, 0, 0};
        tbl[4]  = '{32'h00030002, 0, 10'h000, 1, 0, 0, 0};
        tbl[5]  = '{32'h00000003, 2, 10'h000, 1, 0, 0, 0};
        tbl[6]  = '{32'h00000003, 2, 10'h004, 1, 0, 0, 1};
        tbl[7]  = '{32'h00000005, 2, 10'h008, 0, 0, 0, 0};
        tbl[8]  = '{32'h00000003, 0, 10'h000, 0, 1, 0, 0};
        tbl[9]  = '{32'h00020001, 0, 10'h000, 0, 1, 0, 0};
        tbl[10] = '{32'h00000004, 0, 10'h000, 0, 0, 0, 1};
        tbl[11] = '{32'h00000001, 0, 10'h000, 0, 0, 0, 0};
        tbl[12] = '{32'h12345604, 0, 10'h000, 0, 0, 0, 0};
        tbl[13] = '{32'h00000102, 0, 10'h000, 0, 0, 0, 0};
        tbl[14] = '{32'h01010001, 0, 10'h000, 0, 0, 1, 0};
        tbl[15] = '{32'h00500293, 0, 10'h000, 0, 0, 1, 0};

        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h01);
        check_reset_vals("reset_values");
        step(1'b0, 1'b0, 8'h00);
        n_vec++;
        if (rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b, expected 1", rx_ready);
        end

        // Command table: each word is followed by the cycle that consumes it
        for (int i = 0; i < 16; i++) begin
            send_word(tbl[i].word, tbl[i].gap ? 2 : 0);
            step(1'b0, 1'b0, 8'h00);
            check_row(i, tbl[i]);
        end

        // Reset part-way through a load; the next load restarts at address 0
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        send_word(32'h00030001, 0);
        send_word(32'h11111111, 0);
        send_word(32'h22222222, 0);
        step(1'b0, 1'b1, 8'h33);
        step(1'b0, 1'b1, 8'h44);
        step(1'b1, 1'b0, 8'h00);
        check_reset_vals("reset_mid_load");
        step(1'b0, 1'b0, 8'h00);
        send_word(32'h00010001, 0);
        step(1'b0, 1'b0, 8'h00);
        send_word(32'hCAFEF00D, 0);
        step(1'b0, 1'b0, 8'h00);
        n_vec++;
        if ({i_w_enb, i_w_addr, i_w_dat, busy} !== {1'b1, 10'h000, 32'hCAFEF00D, 1'b0}) begin
            n_fail++;
            $display("FAIL reload_addr0: got %b/%h/%h/%b, expected 1/000/cafef00d/0",
                     i_w_enb, i_w_addr, i_w_dat, busy);
        end

        // Unknown opcode drops into the error state
        send_word(32'h0000007F, 0);
        step(1'b0, 1'b0, 8'h00);
        n_vec++;
        if ({err, rx_ready, pc_stall} !== 3'b101) begin
            n_fail++;
            $display("FAIL bad_opcode: got %b, expected 101", {err, rx_ready, pc_stall});
        end
        send_word(32'h00000003, 0);
        step(1'b0, 1'b0, 8'h00);

        // Largest legal load fills the data BRAM up to the last word address
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        d_wr_seen = 0;
        send_word(32'h01000002, 0);
        step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) send_word($urandom, 0);
        step(1'b0, 1'b0, 8'h00);
        n_vec++;
        if ({d_wr_seen, busy, d_w_addr} !== {256, 1'b0, 10'h3FC}) begin
            n_fail++;
            $display("FAIL max_load: got %0d writes busy=%b last=%h, expected 256 0 3fc",
                     d_wr_seen, busy, d_w_addr);
        end

        // Randomized command streams with idle gaps and occasional resets
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if ((m_mode == MErr && $urandom_range(0, 1) == 1) || r >= 96) begin
                step(1'b1, 1'($urandom), 8'($urandom));
                step(1'b0, 1'b0, 8'h00);
            end else if (r < 60) begin
                n = $urandom_range(0, 6);
                w = {16'(n), 8'($urandom), (r < 30) ? 8'h01 : 8'h02};
                send_word(w, -1);
                for (int j = 0; j < n; j++) send_word($urandom, -1);
            end else if (r < 72) begin
                send_word({24'($urandom), 8'h03}, -1);
            end else if (r < 84) begin
                send_word({24'($urandom), 8'h04}, -1);
            end else if (r < 90) begin
                send_word({24'($urandom), 8'($urandom_range(5, 255))}, -1);
            end else begin
                w = {16'($urandom_range(257, 400)), 8'($urandom), 8'h01};
                send_word(w, -1);
            end
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
